menu_input_controller: RTL and testbench
========================================

MENU_INPUT_CONTROLLER -- requirements
Module: menu_input_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of Clock.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: stable-input cycles required before a key is accepted (10 ms at 50 MHz).
REQ-003 Parameter NUM_MENUS, default 8: browse-mode Selector range is 0..NUM_MENUS-1.
REQ-004 Parameter REPEAT_DELAY, default 25000000: hold cycles before the first auto-repeat.
REQ-005 Parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeats.
REQ-006 Port Clock, input, 1: system clock.
REQ-007 Port Reset, input, 1: synchronous active-high reset.
REQ-008 Port KeyNext_n, input, 1: raw active-low push button; advances the menu.
REQ-009 Port KeyPrev_n, input, 1: raw active-low push button; steps the menu back.
REQ-010 Port KeySel_n, input, 1: raw active-low push button; enters or exits edit mode.
REQ-011 Port KeyInc_n, input, 1: raw active-low push button; requests an increment.
REQ-012 Port Selector, output, 8: menu code consumed by the display multiplexer and the edit blocks.
REQ-013 Port Increment, output, 1: single-cycle active-high increment strobe.
REQ-014 Port EditMode, output, 1: high while in an edit state.

Function
REQ-015 Each key SHALL pass through a two-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-016 A press event SHALL be a one-cycle pulse on the debounced high-to-low transition; releases generate no event.
REQ-017 Total latency from a stable raw press to the Selector/Increment change SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles, all registered outputs.
REQ-018 State machine states SHALL be BROWSE, EDIT_PERSON and EDIT_AREA.
REQ-019 In BROWSE, a Next event SHALL set Selector to (Selector+1) mod NUM_MENUS, wrapping from NUM_MENUS-1 to 0.
REQ-020 In BROWSE, a Prev event SHALL set Selector to Selector-1, wrapping from 0 to NUM_MENUS-1.
REQ-021 If Next and Prev events occur in the same cycle, Selector SHALL NOT change.
REQ-022 In BROWSE, a Sel event SHALL do the following: with Selector=4, go to EDIT_PERSON with Selector=20; with Selector=5, go to EDIT_AREA with Selector=21; otherwise, do nothing.
REQ-023 In an edit state, a Sel event SHALL return to BROWSE, restoring Selector to 4 (from 20) or 5 (from 21).
REQ-024 In edit states, Next and Prev events SHALL be ignored.
REQ-025 Increment SHALL pulse for exactly one cycle per Inc event, and only in edit states; Inc in BROWSE SHALL be ignored.
REQ-026 If Sel and Inc events coincide, Sel SHALL take priority and Increment SHALL stay low.
REQ-027 EditMode SHALL be high exactly while the state is EDIT_PERSON or EDIT_AREA.
REQ-028 The Selector value SHALL always be in 0..NUM_MENUS-1, 20 or 21.

Reset
REQ-029 While Reset is asserted, the state SHALL be BROWSE, Selector SHALL be 0, Increment SHALL be 0 and EditMode SHALL be 0.
REQ-030 Reset SHALL clear the synchronizers to the released level (1), clear the debounce counters, clear the debounced levels to released, and clear the repeat counters, so a key held through reset produces no event until it is released and pressed again.
REQ-031 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no event emitted.

Configuration
REQ-032 Macro MENU_AUTO_REPEAT_EN SHALL control auto-repeat of the Inc key.
REQ-033 With MENU_AUTO_REPEAT_EN defined, holding Inc in an edit state SHALL produce a further Increment pulse REQUIRED REPEAT_DELAY cycles after the press event, then one every REPEAT_PERIOD cycles until release, state exit or reset.
REQ-034 Without MENU_AUTO_REPEAT_EN, the repeat counters SHALL be absent and a held key SHALL produce exactly one pulse.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 for simulation)
REQ-035 Reset, then press Next 8 times -> Selector steps 1,2,...,7,0; press Prev once -> Selector is 7.
REQ-036 Raw Next bouncing with low glitches of 1-3 cycles, then stable low -> exactly one increment of Selector, 7 cycles after the last edge.
REQ-037 At Selector=4, press Sel -> Selector=20 and EditMode=1; press Inc twice -> two single-cycle Increment pulses; press Next -> Selector stays 20; press Sel -> Selector=4.
REQ-038 At Selector=2, press Sel and then Inc -> Selector stays 2 and Increment stays 0; press Next and Prev together -> Selector stays 2.
REQ-039 With the macro defined, in EDIT_AREA hold Inc for 50 cycles after acceptance -> pulses at offsets 0, 20, 28, 36 and 44; without the macro -> only the pulse at offset 0.
REQ-040 Assert Reset while in EDIT_PERSON with Inc held -> Selector=0, EditMode=0 and no Increment pulse until Inc is released and pressed again.

Source files
------------

// File: rtl/menu_input_controller.sv
// Menu input controller: synchronizes and debounces four push buttons, turns
// debounced presses into one-cycle events and steps a small browse/edit FSM
// that drives the display Selector code and the Increment strobe.
// Optional feature macro: MENU_AUTO_REPEAT_EN (auto-repeat of the Inc key).
module menu_input_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_MENUS       = 8,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       KeyNext_n,
    input  logic       KeyPrev_n,
    input  logic       KeySel_n,
    input  logic       KeyInc_n,
    output logic [7:0] Selector,
    output logic       Increment,
    output logic       EditMode
);

    localparam int              CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]      LAST_MENU = 8'(NUM_MENUS - 1);
    localparam logic [7:0]      SEL_PERS  = 8'd20;
    localparam logic [7:0]      SEL_AREA  = 8'd21;

    // Key index: 0 Next, 1 Prev, 2 Sel, 3 Inc (all active low at the pins)
    typedef enum logic [1:0] {BROWSE, EDIT_PERSON, EDIT_AREA} state_t;

    logic [3:0]    w_raw;
    logic [3:0]    r_sync1, r_sync2, r_db, r_evt, r_lock;
    logic [1:0]    r_svld;
    logic [CW-1:0] r_cnt [4];
    state_t        r_state, w_state_n;
    logic [7:0]    w_sel_n;
    logic          w_inc_n;
    logic          w_next, w_prev, w_sel, w_inc, w_rpt;

    assign w_raw = {KeyInc_n, KeySel_n, KeyPrev_n, KeyNext_n};

    // Two-flop synchronizers, per-key debounce counters and press-event pulses.
    // r_lock suppresses the press of a key that was held through reset until
    // the synchronized input has been seen released; r_svld marks when the
    // synchronizer holds real samples again after reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db    <= '1;
            r_evt   <= '0;
            r_lock  <= '1;
            r_svld  <= '0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_svld  <= {r_svld[0], 1'b1};
            for (int k = 0; k < 4; k++) begin
                r_evt[k] <= 1'b0;
                if (r_svld[1] && r_sync2[k]) r_lock[k] <= 1'b0;
                if (r_sync2[k] == r_db[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == DB_LAST) begin
                    r_cnt[k] <= '0;
                    r_db[k]  <= r_sync2[k];
                    r_evt[k] <= ~r_sync2[k] & ~r_lock[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Simultaneous Next and Prev cancel each other
    assign w_next = r_evt[0] & ~r_evt[1];
    assign w_prev = r_evt[1] & ~r_evt[0];
    assign w_sel  = r_evt[2];
    assign w_inc  = r_evt[3] | w_rpt;

`ifdef MENU_AUTO_REPEAT_EN
    logic [31:0] r_rcnt, w_rlim;
    logic        r_rarm, r_rfirst, r_rpt;

    // r_rcnt counts cycles since the last Inc event/repeat; the first repeat
    // waits REPEAT_DELAY, later ones REPEAT_PERIOD
    assign w_rlim = r_rfirst ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1);

    // Auto-repeat timer: armed by an accepted Inc press in an edit state,
    // dropped on release, state exit or reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rcnt   <= '0;
            r_rarm   <= 1'b0;
            r_rfirst <= 1'b0;
            r_rpt    <= 1'b0;
        end else begin
            r_rpt <= 1'b0;
            if (r_evt[3] && !r_evt[2] && r_state != BROWSE) begin
                r_rarm   <= 1'b1;
                r_rfirst <= 1'b1;
                r_rcnt   <= 32'd1;
            end else if (r_rarm && !r_db[3] && r_state != BROWSE) begin
                if (r_rcnt == w_rlim) begin
                    r_rpt    <= 1'b1;
                    r_rcnt   <= '0;
                    r_rfirst <= 1'b0;
                end else begin
                    r_rcnt <= r_rcnt + 32'd1;
                end
            end else begin
                r_rarm   <= 1'b0;
                r_rfirst <= 1'b0;
                r_rcnt   <= '0;
            end
        end
    end

    assign w_rpt = r_rpt;
`else
    // No repeat timer: the repeat parameters only appear in this constant-false term
    assign w_rpt = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

    // Next-state, next-Selector and Increment decode; Sel beats Inc
    always_comb begin
        w_state_n = r_state;
        w_sel_n   = Selector;
        w_inc_n   = 1'b0;
        case (r_state)
            BROWSE: begin
                if (w_sel) begin
                    if (Selector == 8'd4) begin
                        w_state_n = EDIT_PERSON;
                        w_sel_n   = SEL_PERS;
                    end else if (Selector == 8'd5) begin
                        w_state_n = EDIT_AREA;
                        w_sel_n   = SEL_AREA;
                    end
                end else if (w_next) begin
                    w_sel_n = (Selector >= LAST_MENU) ? 8'd0 : Selector + 8'd1;
                end else if (w_prev) begin
                    w_sel_n = (Selector == 8'd0) ? LAST_MENU : Selector - 8'd1;
                end
            end
            EDIT_PERSON: begin
                if (w_sel) begin
                    w_state_n = BROWSE;
                    w_sel_n   = 8'd4;
                end else begin
                    w_inc_n = w_inc;
                end
            end
            EDIT_AREA: begin
                if (w_sel) begin
                    w_state_n = BROWSE;
                    w_sel_n   = 8'd5;
                end else begin
                    w_inc_n = w_inc;
                end
            end
            default: begin
                w_state_n = BROWSE;
                w_sel_n   = 8'd0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= BROWSE;
            Selector  <= 8'd0;
            Increment <= 1'b0;
            EditMode  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            Selector  <= w_sel_n;
            Increment <= w_inc_n;
            EditMode  <= (w_state_n != BROWSE);
        end
    end

endmodule

// File: tb/tb_menu_input_controller.sv
// Bench for menu_input_controller with short debounce/repeat timing.
// Each key press pushes the expected Selector/EditMode/pulse count onto a
// scoreboard queue, popped and compared once the press has settled.
module tb_menu_input_controller;

    localparam int DB = 4;
    localparam int NM = 8;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] keys_n = 4'hF;   // {Inc, Sel, Prev, Next}
    logic [7:0] Selector;
    logic       Increment, EditMode;

    always #5 Clock = ~Clock;

    menu_input_controller #(
        .DEBOUNCE_CYCLES(DB), .NUM_MENUS(NM), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .KeyNext_n(keys_n[0]), .KeyPrev_n(keys_n[1]),
        .KeySel_n(keys_n[2]), .KeyInc_n(keys_n[3]),
        .Selector(Selector), .Increment(Increment), .EditMode(EditMode)
    );

    typedef struct {int sel; int edit; int ninc;} exp_t;

    exp_t exp_q[$];
    int   inc_q[$];
    int   off_q[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0;
    int   max_run = 0;
    int   m_sel = 0, m_edit = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Increment monitor: pulse timestamps and longest high run
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge Clock);
            if (Increment === 1'b1) begin
                inc_q.push_back(cyc);
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        tick(3);
        chk({tag, "_sel"}, int'(Selector), 0);
        chk({tag, "_edit"}, int'(EditMode), 0);
        chk({tag, "_inc"}, int'(Increment), 0);
        Reset = 1'b0;
        m_sel  = 0;
        m_edit = 0;
        tick(2);
        inc_q.delete();
    endtask

    // Press the keys in mask together, release, let everything settle, compare
    task automatic press(input logic [3:0] mask, input string tag);
        exp_t e;
        e.ninc = 0;
        if (m_edit == 0) begin
            if (mask[2]) begin
                if (m_sel == 4)      begin m_edit = 1; m_sel = 20; end
                else if (m_sel == 5) begin m_edit = 1; m_sel = 21; end
            end else if (mask[0] && !mask[1]) m_sel = (m_sel + 1) % NM;
            else if (mask[1] && !mask[0])     m_sel = (m_sel + NM - 1) % NM;
        end else begin
            if (mask[2]) begin
                m_sel  = (m_sel == 20) ? 4 : 5;
                m_edit = 0;
            end else if (mask[3]) e.ninc = 1;
        end
        e.sel  = m_sel;
        e.edit = m_edit;
        exp_q.push_back(e);
        inc_q.delete();
        keys_n = ~mask;
        tick(8);
        keys_n = 4'hF;
        tick(10);
        e = exp_q.pop_front();
        chk({tag, "_sel"}, int'(Selector), e.sel);
        chk({tag, "_edit"}, int'(EditMode), e.edit);
        chk({tag, "_ninc"}, inc_q.size(), e.ninc);
    endtask

    initial begin
        int c0, nexp, got;
        do_reset("rst0");

        // Browse wrap forwards and backwards
        for (int i = 0; i < 8; i++) press(4'b0001, "next");
        press(4'b0010, "prev_wrap");

        // Bouncing Next: only the final stable low is accepted
        keys_n[0] = 1'b0; tick(1); keys_n[0] = 1'b1; tick(2);
        keys_n[0] = 1'b0; tick(3); keys_n[0] = 1'b1; tick(1);
        keys_n[0] = 1'b0; tick(2); keys_n[0] = 1'b1; tick(2);
        inc_q.delete();
        keys_n[0] = 1'b0;
        tick(6);
        chk("bounce_early", int'(Selector), 7);
        tick(1);
        chk("bounce_step", int'(Selector), 0);
        tick(4);
        keys_n[0] = 1'b1;
        tick(10);
        m_sel = 0;
        chk("bounce_final", int'(Selector), 0);

        // Person edit: enter, two increments, Next ignored, exit
        for (int i = 0; i < 4; i++) press(4'b0001, "to4");
        press(4'b0100, "sel_person");
        press(4'b1000, "inc1");
        press(4'b1000, "inc2");
        press(4'b0001, "next_in_edit");
        press(4'b0100, "sel_exit4");

        // Sel at a non-editable menu, Inc in browse, Next+Prev together
        press(4'b0010, "to3");
        press(4'b0010, "to2");
        press(4'b0100, "sel_at2");
        press(4'b1000, "inc_browse");
        press(4'b0011, "next_prev");

        // Area edit and held Inc
        for (int i = 0; i < 3; i++) press(4'b0001, "to5");
        press(4'b0100, "sel_area");
        off_q.delete();
        off_q.push_back(7);
`ifdef MENU_AUTO_REPEAT_EN
        off_q.push_back(7 + RD);
        off_q.push_back(7 + RD + RP);
        off_q.push_back(7 + RD + 2 * RP);
        off_q.push_back(7 + RD + 3 * RP);
`endif
        nexp = off_q.size();
        inc_q.delete();
        c0 = cyc;
        keys_n[3] = 1'b0;
        tick(50);
        keys_n[3] = 1'b1;
        tick(12);
        chk("hold_npulse", inc_q.size(), nexp);
        for (int i = 0; i < nexp; i++) begin
            got = (i < inc_q.size()) ? inc_q[i] - c0 : -1;
            chk("hold_pulse_at", got, off_q.pop_front());
        end
        chk("hold_sel", int'(Selector), 21);

        // Reset in EDIT_PERSON with Inc and Next held through it
        press(4'b0100, "sel_exit5");
        press(4'b0010, "back4");
        press(4'b0100, "sel_person2");
        inc_q.delete();
        keys_n = 4'b0110;
        tick(10);
        chk("held_pre_reset_ninc", inc_q.size(), 1);
        do_reset("rst_held");
        tick(40);
        chk("held_post_ninc", inc_q.size(), 0);
        chk("held_post_sel", int'(Selector), 0);
        chk("held_post_edit", int'(EditMode), 0);
        keys_n = 4'hF;
        tick(10);
        press(4'b0001, "after_release");

        chk("inc_width", max_run, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
